mult_display_driver: RTL and testbench

- Drives the signed multiplier result onto the 4-digit seven-segment display.
- Accepts a signed 16-bit product on a load strobe and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) FSM.
- Holds the converted digits and time-multiplexes them: it produces the digit-select index and the 4-bit digit code that the seven-segment decoder consumes.

---
 rtl/mult_display_pkg.sv | 7 +
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/mult_display_driver.sv | 59 +++++
 tb/tb_mult_display_driver.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mult_display_pkg.sv
// mult_display_pkg: shared digit codes, BCD size and converter FSM states
package mult_display_pkg;
  localparam int NUM_DIGITS = 5;
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd15;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to 5-digit BCD converter
module bin2bcd_seq
  import mult_display_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);
  localparam int CW = $clog2(WIDTH);
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    case (state_q)
      IDLE: if (start_i) begin
        bin_d   = bin_i;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        state_d        = cnt_q == CW'(WIDTH - 1) ? COMMIT : SHIFT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == COMMIT;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/mult_display_driver.sv
// mult_display_driver: signed product to multiplexed 4-position BCD display codes
module mult_display_driver
  import mult_display_pkg::*;
#(
  parameter int REFRESH_BITS = 20,
  parameter int WIDTH        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] product,
  input  logic             load,
  input  logic             scroll,
  output logic             busy,
  output logic [1:0]       toggle,
  output logic [3:0]       digit
);
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              toggle_q;
  logic                    sign_cap_q, sign_q, start, done;
  logic [WIDTH-1:0]        mag;
  logic [4*NUM_DIGITS-1:0] bcd, disp_q, hi;
  logic [2:0]              k;
  // two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned
  assign mag   = product[WIDTH-1] ? ~product + 1'b1 : product;
  assign start = load & ~busy;
  bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (mag),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      refresh_q  <= '0;
      toggle_q   <= '0;
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
      disp_q     <= '0;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      toggle_q  <= refresh_q[REFRESH_BITS-1 -: 2];
      if (start) sign_cap_q <= product[WIDTH-1];
      if (done) begin
        disp_q <= bcd;
        sign_q <= sign_cap_q && bcd != '0;
      end
    end
  // hi holds the shown digit in its low nibble and all more-significant digits above it
  always_comb begin
    k     = {1'b0, toggle_q} + (scroll ? 3'd2 : 3'd0);
    hi    = disp_q >> {k, 2'b00};
    digit = toggle_q == 2'd3 ? (sign_q ? DIG_MINUS : DIG_BLANK) :
            (toggle_q != 2'd0 && hi == '0) ? DIG_BLANK : hi[3:0];
  end
  assign toggle = toggle_q;
endmodule

// File: tb/tb_mult_display_driver.sv
// tb_mult_display_driver: directed scoreboard bench, REFRESH_BITS=4
module tb_mult_display_driver;
  typedef struct packed {
    logic [1:0] pos;
    logic [3:0] exp;
  } item_t;

  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, scroll = 1'b0;
  logic [15:0] product = '0;
  logic        busy;
  logic [1:0]  toggle;
  logic [3:0]  digit;
  int          checks = 0, failures = 0;
  item_t       sb[$];

  mult_display_driver #(.REFRESH_BITS(4), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .product(product), .load(load),
    .scroll(scroll), .busy(busy), .toggle(toggle), .digit(digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: compares the head entry whenever the display reaches its position
  initial begin : monitor
    int waited = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 || !rst_n) begin
        waited = 0;
      end else if (toggle == sb[0].pos) begin
        check($sformatf("pos%0d", sb[0].pos), digit, sb[0].exp);
        void'(sb.pop_front());
        waited = 0;
      end else if (++waited > 40) begin
        check($sformatf("pos%0d_timeout", sb[0].pos), -1, sb[0].exp);
        void'(sb.pop_front());
        waited = 0;
      end
    end
  end

  task automatic view(input logic sc, input int e0, input int e1, input int e2, input int e3);
    int n = 0;
    scroll = sc;
    @(negedge clk);
    sb.push_back({2'd0, 4'(e0)});
    sb.push_back({2'd1, 4'(e1)});
    sb.push_back({2'd2, 4'(e2)});
    sb.push_back({2'd3, 4'(e3)});
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("view_drain", sb.size(), 0);
  endtask

  task automatic pulse(input logic [15:0] p);
    @(negedge clk);
    product = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_toggle", toggle, 0);
    check("rst_digit", digit, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    view(1'b0, 0, 15, 15, 15);

    pulse(-16'sd1234);
    wait_idle(n);
    check("busy_cycles", n, 17);
    view(1'b0, 4, 3, 2, 10);
    view(1'b1, 2, 1, 15, 10);

    pulse(16'd16384);
    wait_idle(n);
    view(1'b1, 3, 6, 1, 15);
    view(1'b0, 4, 8, 3, 15);

    pulse(16'h8000);
    wait_idle(n);
    view(1'b1, 7, 2, 3, 10);

    pulse(16'd0);
    wait_idle(n);
    view(1'b0, 0, 15, 15, 15);

    pulse(16'd77);
    @(negedge clk);
    product = 16'd5;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    wait_idle(n);
    check("ignored_load_busy", n, 15);
    view(1'b0, 7, 7, 15, 15);

    pulse(-16'sd1234);
    repeat (7) @(negedge clk);
    check("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_toggle", toggle, 0);
    check("abort_digit", digit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    view(1'b0, 0, 15, 15, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
